// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register feeding the ALU: operand capture, RAW forwarding and load-use stall.
// Optional macro ALU_OPSTAGE_FWD_EN enables forwarding; without it, RAW hazards stall until writeback.
`ifndef ALU_ADD
`define ALU_ADD 0
`endif

module alu_operand_stage #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 6,
    parameter int REG_AW = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              id_valid,
    input  logic [SEL_W-1:0]  id_alusel,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [DATA_W-1:0] id_rs1_data,
    input  logic [DATA_W-1:0] id_rs2_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc,
    input  logic              id_srca_pc,
    input  logic              id_srcb_imm,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic              exm_regwrite,
    input  logic [DATA_W-1:0] exm_result,
    input  logic [REG_AW-1:0] mwb_rd,
    input  logic              mwb_regwrite,
    input  logic [DATA_W-1:0] mwb_result,
    input  logic              flush,
    input  logic              hold,
    output logic              stall,
    output logic              ex_valid,
    output logic [SEL_W-1:0]  ALUctl,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic [DATA_W-1:0] ex_store_data
);
    localparam logic [SEL_W-1:0] ADD_SEL = SEL_W'(`ALU_ADD);

    logic              valid_q, valid_d;
    logic              regwrite_q, regwrite_d;
    logic              memread_q, memread_d;
    logic [SEL_W-1:0]  alusel_q;
    logic [REG_AW-1:0] rs1_q, rs2_q, rd_q;
    logic [DATA_W-1:0] rs1_data_q, rs2_data_q, imm_q, pc_q;
    logic              srca_pc_q, srcb_imm_q;

    logic              ex_hit, lu, kill, load_en;
    logic [DATA_W-1:0] fwd_rs1, fwd_rs2;

    assign ex_hit = (rd_q != '0) & ((rd_q == id_rs1) | (rd_q == id_rs2));

`ifdef ALU_OPSTAGE_FWD_EN
    logic exm_ok, mwb_ok;

    assign lu = id_valid & valid_q & memread_q & ex_hit;

    assign exm_ok  = exm_regwrite & (exm_rd != '0);
    assign mwb_ok  = mwb_regwrite & (mwb_rd != '0);
    // EX/MEM is younger than MEM/WB, so it is checked first
    assign fwd_rs1 = (exm_ok && exm_rd == rs1_q) ? exm_result :
                     (mwb_ok && mwb_rd == rs1_q) ? mwb_result : rs1_data_q;
    assign fwd_rs2 = (exm_ok && exm_rd == rs2_q) ? exm_result :
                     (mwb_ok && mwb_rd == rs2_q) ? mwb_result : rs2_data_q;
`else
    logic exm_hit;
    logic unused_fwd;

    // Any in-flight producer blocks the consumer until the write-first RF supplies the value
    assign exm_hit = exm_regwrite & (exm_rd != '0) & ((exm_rd == id_rs1) | (exm_rd == id_rs2));
    assign lu      = id_valid & (((valid_q & memread_q) | regwrite_q) & ex_hit | exm_hit);

    assign fwd_rs1    = rs1_data_q;
    assign fwd_rs2    = rs2_data_q;
    assign unused_fwd = ^{mwb_rd, mwb_regwrite, mwb_result, exm_result, rs1_q, rs2_q};
`endif

    assign stall   = lu | hold;
    assign kill    = flush | (~hold & lu);
    assign load_en = ~flush & ~hold & ~lu;

    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        if (kill) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
        end else if (load_en) begin
            valid_d    = id_valid;
            regwrite_d = id_valid & id_regwrite;
            memread_d  = id_valid & id_memread;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
        end
    end

    // Data fields change only on a real load; bubbles and flushes leave them intact
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            alusel_q   <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            pc_q       <= '0;
            srca_pc_q  <= 1'b0;
            srcb_imm_q <= 1'b0;
            rd_q       <= '0;
        end else if (load_en) begin
            alusel_q   <= id_alusel;
            rs1_q      <= id_rs1;
            rs2_q      <= id_rs2;
            rs1_data_q <= id_rs1_data;
            rs2_data_q <= id_rs2_data;
            imm_q      <= id_imm;
            pc_q       <= id_pc;
            srca_pc_q  <= id_srca_pc;
            srcb_imm_q <= id_srcb_imm;
            rd_q       <= id_rd;
        end
    end

    assign ex_valid      = valid_q;
    assign ALUctl        = valid_q ? alusel_q : ADD_SEL;
    assign A             = srca_pc_q ? pc_q : fwd_rs1;
    assign B             = srcb_imm_q ? imm_q : fwd_rs2;
    assign ex_store_data = fwd_rs2;
    assign ex_rd         = rd_q;
    assign ex_regwrite   = regwrite_q;
    assign ex_memread    = memread_q;

endmodule
